// File: rtl/uncache_pkg.sv
// rtl/uncache_pkg.sv - shared types and constants for the uncached data bridge
//
// Purpose: bridge state encoding, AXI AxSIZE encodings, the default AXI ID
// and a helper that maps the CPU access size onto AxSIZE.
// Ports: none (package).
package uncache_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WADDR = 3'd3,
      WRESP = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [2:0] AXSIZE_BYTE = 3'd0;
   localparam logic [2:0] AXSIZE_HALF = 3'd1;
   localparam logic [2:0] AXSIZE_WORD = 3'd2;

   localparam logic [3:0] UNCACHE_DEFAULT_ID = 4'd1;

   // CPU size 0/1/2 maps straight onto AxSIZE; an out-of-range size is
   // passed through zero-extended rather than clamped.
   function automatic logic [2:0] axi_size(input logic [1:0] size);
      case (size)
         2'd0:    axi_size = AXSIZE_BYTE;
         2'd1:    axi_size = AXSIZE_HALF;
         2'd2:    axi_size = AXSIZE_WORD;
         default: axi_size = 3'd3;
      endcase
   endfunction

endpackage

// File: rtl/uncache_wbuf.sv
// rtl/uncache_wbuf.sv - single-entry posted write buffer for uncached stores
//
// Purpose: holds one posted store (address, size, data, strobes) plus a
// pending flag and drives the AXI AW/W/B channels for it in the background.
// The owner must only push while pending is low.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   push, push_*                 capture a store into the buffer
//   pending                      a buffered write has not yet seen bvalid
//   awvalid/awready/awaddr/awsize  AXI write address channel
//   wvalid/wready/m_wdata/m_wstrb  AXI write data channel
//   bvalid/bready                AXI write response channel
module uncache_wbuf
   import uncache_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        push,
   input  logic [31:0] push_addr,
   input  logic [1:0]  push_size,
   input  logic [31:0] push_wdata,
   input  logic [3:0]  push_wstrb,
   output logic        pending,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        bvalid,
   output logic        bready
);

   logic        pend_q;
   logic        aw_done_q;
   logic        w_done_q;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic [31:0] data_q;
   logic [3:0]  strb_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_q    <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         addr_q    <= '0;
         size_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
      end else if (push) begin
         pend_q    <= 1'b1;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         addr_q    <= push_addr;
         size_q    <= push_size;
         data_q    <= push_wdata;
         strb_q    <= push_wstrb;
      end else if (pend_q) begin
         if (awvalid && awready) aw_done_q <= 1'b1;
         if (wvalid && wready)   w_done_q  <= 1'b1;
         if (bvalid && bready)   pend_q    <= 1'b0;
      end
   end

   // Valids come only from registered flags, never from the readies.
   assign awvalid = pend_q & ~aw_done_q;
   assign wvalid  = pend_q & ~w_done_q;
   assign bready  = pend_q & aw_done_q & w_done_q;
   assign pending = pend_q;
   assign awaddr  = addr_q;
   assign awsize  = axi_size(size_q);
   assign m_wdata = data_q;
   assign m_wstrb = strb_q;

endmodule

// File: rtl/d_uncache_bridge.sv
// rtl/d_uncache_bridge.sv - CPU uncached data access to single-beat AXI bridge
//
// Purpose: turns one held CPU uncached load/store request into a single AXI
// read or write transaction and returns a one-cycle data_ok pulse.
// Optional build macro UNCACHE_WBUF_EN: stores are posted into uncache_wbuf
// and acknowledged the cycle after acceptance; later accesses wait in IDLE
// until the buffered write has received bvalid.
// Ports:
//   clk, resetn                          clock, asynchronous active-low reset
//   req, wr, size, paddr, wdata, wstrb   CPU request (held until data_ok)
//   data_ok, rdata                       CPU completion pulse and load data
//   arvalid/arready/araddr/arsize/arid   AXI read address channel
//   rvalid/rready/m_rdata/rlast          AXI read data channel
//   awvalid/awready/awaddr/awsize/awid   AXI write address channel
//   wvalid/wready/m_wdata/m_wstrb/wlast  AXI write data channel
//   bvalid/bready                        AXI write response channel
module d_uncache_bridge
   import uncache_pkg::*;
#(
   parameter logic [3:0] AXI_ID = UNCACHE_DEFAULT_ID
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] paddr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic [3:0]  arid,
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] m_rdata,
   input  logic        rlast,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic [3:0]  awid,
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        wlast,
   input  logic        bvalid,
   output logic        bready
);

   state_t      state_q;
   state_t      state_d;
   logic        accept;
   logic        wbuf_busy;
   logic        aw_hs;
   logic        w_hs;
   logic        aw_done_q;
   logic        w_done_q;
   logic        wr_q;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] rdata_q;
   logic        unused_sig;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && !wbuf_busy) begin
               accept = 1'b1;
               if (!wr) begin
                  state_d = RADDR;
               end else begin
`ifdef UNCACHE_WBUF_EN
                  state_d = DONE;
`else
                  state_d = WADDR;
`endif
               end
            end
         end
         RADDR: if (arready) state_d = RDATA;
         RDATA: if (rvalid)  state_d = DONE;
         // Each channel may finish in an earlier cycle (flag) or this one.
         WADDR: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WRESP;
         WRESP: if (bvalid)  state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            wr_q      <= wr;
            addr_q    <= paddr;
            size_q    <= size;
            wdata_q   <= wdata;
            wstrb_q   <= wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
         end
         if (state_q == RDATA && rvalid) rdata_q <= m_rdata;
      end
   end

   assign arvalid = (state_q == RADDR);
   assign araddr  = addr_q;
   assign arsize  = axi_size(size_q);
   assign arid    = AXI_ID;
   assign rready  = (state_q == RDATA);
   assign rdata   = rdata_q;
   assign data_ok = (state_q == DONE);
   assign awid    = AXI_ID;
   assign wlast   = 1'b1;

`ifdef UNCACHE_WBUF_EN
   uncache_wbuf u_wbuf (
      .clk        (clk),
      .resetn     (resetn),
      .push       (accept & wr),
      .push_addr  (paddr),
      .push_size  (size),
      .push_wdata (wdata),
      .push_wstrb (wstrb),
      .pending    (wbuf_busy),
      .awvalid    (awvalid),
      .awready    (awready),
      .awaddr     (awaddr),
      .awsize     (awsize),
      .wvalid     (wvalid),
      .wready     (wready),
      .m_wdata    (m_wdata),
      .m_wstrb    (m_wstrb),
      .bvalid     (bvalid),
      .bready     (bready)
   );

   // Stores never pass through WADDR/WRESP in this build.
   assign aw_hs      = 1'b0;
   assign w_hs       = 1'b0;
   assign unused_sig = ^{rlast, wr_q, wdata_q, wstrb_q};
`else
   assign wbuf_busy  = 1'b0;
   assign awvalid    = (state_q == WADDR) & ~aw_done_q;
   assign wvalid     = (state_q == WADDR) & ~w_done_q;
   assign aw_hs      = awvalid & awready;
   assign w_hs       = wvalid & wready;
   assign awaddr     = addr_q;
   assign awsize     = axi_size(size_q);
   assign m_wdata    = wdata_q;
   assign m_wstrb    = wstrb_q;
   assign bready     = (state_q == WRESP);
   assign unused_sig = ^{rlast, wr_q};
`endif

endmodule

// File: tb/tb_d_uncache_bridge.sv
// tb/tb_d_uncache_bridge.sv - scoreboard testbench for d_uncache_bridge
module tb_d_uncache_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req, wr;
   logic [1:0]  size;
   logic [31:0] paddr, wdata;
   logic [3:0]  wstrb;
   logic        data_ok;
   logic [31:0] rdata;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic [3:0]  arid;
   logic        rvalid, rready, rlast;
   logic [31:0] m_rdata;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic [3:0]  awid;
   logic        wvalid, wready, wlast;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        bvalid, bready;

   always #5 clk = ~clk;

   d_uncache_bridge dut (
      .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
      .paddr(paddr), .wdata(wdata), .wstrb(wstrb), .data_ok(data_ok),
      .rdata(rdata), .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .arsize(arsize), .arid(arid), .rvalid(rvalid), .rready(rready),
      .m_rdata(m_rdata), .rlast(rlast), .awvalid(awvalid), .awready(awready),
      .awaddr(awaddr), .awsize(awsize), .awid(awid), .wvalid(wvalid),
      .wready(wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready)
   );

   typedef struct { bit is_load; logic [31:0] data; } exp_t;
   typedef struct { logic [31:0] addr; logic [2:0] sz; } ax_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; } wexp_t;

   exp_t  exp_q[$];
   ax_t   ar_exp_q[$];
   ax_t   aw_exp_q[$];
   wexp_t w_exp_q[$];

   logic [31:0] ref_mem   [logic [29:0]];
   logic [31:0] slave_mem [logic [29:0]];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   int write_outstanding = 0;
   int order_viol = 0;
   int aw_hs_cyc = 0, b_hs_cyc = 0, dok_cyc = 0, bready_rise_cyc = 0;
   bit saw_aw_only = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [29:0] w);
      logic [31:0] x;
      x = {2'b00, w};
      return (x * 32'h0001_0003) ^ 32'h5EED_1234;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
      return init_word(a[31:2]);
   endfunction

   function automatic logic [31:0] slave_read(input logic [31:0] a);
      if (slave_mem.exists(a[31:2])) return slave_mem[a[31:2]];
      return init_word(a[31:2]);
   endfunction

   // Reference model: CPU-level effect of each access, computed at issue time.
   task automatic issue(input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      exp_t e;
      ax_t  ax;
      wexp_t we;
      ax.addr = a;
      ax.sz   = {1'b0, sz};
      if (!w) begin
         e.is_load = 1'b1;
         e.data    = ref_read(a);
         ar_exp_q.push_back(ax);
      end else begin
         e.is_load = 1'b0;
         e.data    = '0;
         we.data   = d;
         we.strb   = s;
         aw_exp_q.push_back(ax);
         w_exp_q.push_back(we);
         ref_mem[a[31:2]] = merge(ref_read(a), d, s);
         write_outstanding++;
      end
      exp_q.push_back(e);
      req = 1'b1; wr = w; size = sz; paddr = a; wdata = d; wstrb = s;
   endtask

   task automatic wait_done(output int lat);
      bit got;
      got = 0;
      lat = 0;
      while (!got && lat < 300) begin
         @(negedge clk);
         lat++;
         got = data_ok;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL data_ok_timeout: got no data_ok expected one within 300 cycles");
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (write_outstanding != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (write_outstanding != 0) begin
         checks++; errors++;
         $display("FAIL write_drain_timeout: got %0d outstanding expected 0", write_outstanding);
      end
   endtask

   // AXI slave: per-channel wait counters, memory committed on B handshake.
   int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   bit r_active = 0, aw_got = 0, w_got = 0, b_active = 0;
   logic [31:0] r_data, cap_addr, cap_data;
   logic [3:0]  cap_strb;
   ax_t   s_ax;
   wexp_t s_w;

   initial begin
      arready = 0; rvalid = 0; rlast = 0; m_rdata = '0;
      awready = 0; wready = 0; bvalid = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
            r_active = 0; aw_got = 0; w_got = 0; b_active = 0;
            ar_wait = ar_dly; aw_wait = aw_dly; w_wait = w_dly;
         end else begin
            if (b_active) begin
               if (b_wait == 0) begin
                  bvalid = 1;
                  if (bready) begin
                     slave_mem[cap_addr[31:2]] = merge(slave_read(cap_addr), cap_data, cap_strb);
                     b_active = 0; aw_got = 0; w_got = 0;
                     write_outstanding--;
                     b_hs_cyc = cyc;
                  end
               end else begin
                  bvalid = 0;
                  b_wait--;
               end
            end else bvalid = 0;

            if (r_active) begin
               if (r_wait == 0) begin
                  rvalid = 1; rlast = 1; m_rdata = r_data;
                  if (rready) r_active = 0;
               end else begin
                  rvalid = 0; rlast = 0; m_rdata = $urandom;
                  r_wait--;
               end
            end else begin
               rvalid = 0; rlast = 0;
            end

            if (arvalid && !r_active) begin
               if (ar_wait == 0) begin
                  arready = 1;
                  if (ar_exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL ar_unexpected: got araddr %h expected no read", araddr);
                  end else begin
                     s_ax = ar_exp_q.pop_front();
                     check("araddr", araddr, s_ax.addr);
                     check("arsize", {29'd0, arsize}, {29'd0, s_ax.sz});
                     check("arid", {28'd0, arid}, 32'd1);
                  end
                  r_data = slave_read(araddr);
                  r_active = 1;
                  r_wait = r_dly;
               end else begin
                  arready = 0;
                  ar_wait--;
               end
            end else begin
               arready = 0;
               ar_wait = ar_dly;
            end

            if (awvalid && !aw_got) begin
               if (aw_wait == 0) begin
                  awready = 1;
                  if (aw_exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL aw_unexpected: got awaddr %h expected no write", awaddr);
                  end else begin
                     s_ax = aw_exp_q.pop_front();
                     check("awaddr", awaddr, s_ax.addr);
                     check("awsize", {29'd0, awsize}, {29'd0, s_ax.sz});
                     check("awid", {28'd0, awid}, 32'd1);
                  end
                  cap_addr = awaddr;
                  aw_got = 1;
                  aw_hs_cyc = cyc;
               end else begin
                  awready = 0;
                  aw_wait--;
               end
            end else begin
               awready = 0;
               aw_wait = aw_dly;
            end

            if (wvalid && !w_got) begin
               if (w_wait == 0) begin
                  wready = 1;
                  if (w_exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL w_unexpected: got wdata %h expected no write", m_wdata);
                  end else begin
                     s_w = w_exp_q.pop_front();
                     check("m_wdata", m_wdata, s_w.data);
                     check("m_wstrb", {28'd0, m_wstrb}, {28'd0, s_w.strb});
                     check("wlast", {31'd0, wlast}, 32'd1);
                  end
                  cap_data = m_wdata;
                  cap_strb = m_wstrb;
                  w_got = 1;
               end else begin
                  wready = 0;
                  w_wait--;
               end
            end else begin
               wready = 0;
               w_wait = w_dly;
            end

            if (aw_got && w_got && !b_active) begin
               b_active = 1;
               b_wait = b_dly;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT reports completion.
   bit   prev_dok = 0;
   bit   prev_bready = 0;
   exp_t m_e;
   initial begin
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (data_ok) begin
               check("data_ok_single_cycle", {31'd0, prev_dok}, 32'd0);
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL data_ok_unexpected: got data_ok expected no completion");
               end else begin
                  m_e = exp_q.pop_front();
                  if (m_e.is_load) check("rdata", rdata, m_e.data);
               end
               dok_cyc = cyc;
            end
            if (arvalid && write_outstanding > 0) order_viol++;
            if (awvalid && !wvalid) saw_aw_only = 1;
            if (bready && !prev_bready) bready_rise_cyc = cyc;
         end
         prev_dok = data_ok;
         prev_bready = bready;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected completion before 900000");
      $fatal(1, "watchdog");
   end

   int lat, cnt;
   logic [31:0] a;

   initial begin
      resetn = 0; req = 0; wr = 0; size = 0; paddr = 0; wdata = 0; wstrb = 0;
      repeat (2) @(negedge clk);
      check("rst_arvalid", {31'd0, arvalid}, 0);
      check("rst_awvalid", {31'd0, awvalid}, 0);
      check("rst_wvalid",  {31'd0, wvalid}, 0);
      check("rst_rready",  {31'd0, rready}, 0);
      check("rst_bready",  {31'd0, bready}, 0);
      check("rst_data_ok", {31'd0, data_ok}, 0);
      check("rst_rdata",   rdata, 0);
      resetn = 1;
      @(negedge clk);

      // Zero-wait load: minimum latency 3.
      ref_mem[30'h1FAF_0000 >> 2]   = 32'hDEAD_BEEF;
      slave_mem[30'h1FAF_0000 >> 2] = 32'hDEAD_BEEF;
      issue(0, 2'd2, 32'h1FAF_0000, 0, 0);
      wait_done(lat);
      req = 0;
      check("load_latency", lat, 3);

      // Store with late awready: W finishes first, WRESP follows AW.
      aw_dly = 3; w_dly = 0; b_dly = 0; saw_aw_only = 0;
      issue(1, 2'd2, 32'h1FAF_F000, 32'h1234_5678, 4'hF);
      wait_done(lat);
      req = 0;
`ifdef UNCACHE_WBUF_EN
      check("posted_store_latency", lat, 1);
      wait_idle();
`else
      check("dok_after_bvalid", dok_cyc - b_hs_cyc, 1);
`endif
      check("wvalid_drops_first", {31'd0, saw_aw_only}, 1);
      check("wresp_after_awready", bready_rise_cyc - aw_hs_cyc, 1);
      aw_dly = 0;

      // Byte store on an unaligned address, then read the word back.
      issue(1, 2'd0, 32'h0010_0003, 32'hA5A5_A5A5, 4'h8);
      wait_done(lat);
      issue(0, 2'd2, 32'h0010_0000, 0, 0);
      wait_done(lat);
      req = 0;

      // Reset while waiting for rvalid abandons the load.
      r_dly = 8;
      @(negedge clk);
      issue(0, 2'd2, 32'h1FAF_0004, 0, 0);
      cnt = 0;
      while (!rready && cnt < 50) begin @(negedge clk); cnt++; end
      check("rready_before_reset", {31'd0, rready}, 1);
      resetn = 0;
      #1;
      check("reset_arvalid", {31'd0, arvalid}, 0);
      check("reset_rready", {31'd0, rready}, 0);
      check("reset_rdata", rdata, 0);
      exp_q.delete();
      req = 0;
      cnt = 0;
      repeat (3) begin @(negedge clk); if (data_ok) cnt++; end
      resetn = 1;
      r_dly = 0;
      repeat (4) begin @(negedge clk); if (data_ok) cnt++; end
      check("no_data_ok_after_reset", cnt, 0);
      issue(0, 2'd2, 32'h1FAF_0000, 0, 0);
      wait_done(lat);
      req = 0;
      check("load_after_reset_latency", lat, 3);

      // Store then load back-to-back with a slow write response.
      b_dly = 5;
      issue(1, 2'd2, 32'h1FAF_0008, 32'hCAFE_F00D, 4'hF);
      wait_done(lat);
`ifdef UNCACHE_WBUF_EN
      check("posted_store_dok", lat, 1);
`endif
      issue(0, 2'd2, 32'h1FAF_0008, 0, 0);
      wait_done(lat);
      req = 0;
      b_dly = 0;

      // Randomized mix of loads and stores with random slave delays.
      for (int i = 0; i < 40; i++) begin
         ar_dly = $urandom_range(0, 3);
         r_dly  = $urandom_range(0, 3);
         aw_dly = $urandom_range(0, 3);
         w_dly  = $urandom_range(0, 3);
         b_dly  = $urandom_range(0, 4);
         a = 32'h1FA0_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         issue($urandom_range(0, 1) == 1, 2'($urandom_range(0, 2)), a, $urandom,
               4'($urandom_range(1, 15)));
         wait_done(lat);
         if ($urandom_range(0, 1) == 1) begin
            req = 0;
            @(negedge clk);
         end
      end
      req = 0;
      wait_idle();
      repeat (3) @(negedge clk);

      check("scoreboard_empty", exp_q.size(), 0);
      check("ar_queue_empty", ar_exp_q.size(), 0);
      check("aw_queue_empty", aw_exp_q.size(), 0);
      check("w_queue_empty", w_exp_q.size(), 0);
      check("read_after_write_order", order_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
